// File: rtl/partida_pkg.sv
// Shared encodings and helpers for the naval-battle round controller:
// state codes, board geometry, cell indexing and ship-cell counting.
package partida_pkg;

    localparam int unsigned NUM_COLUNAS  = 5;
    localparam int unsigned NUM_LINHAS   = 7;
    localparam int unsigned NUM_CELULAS  = 35;
    localparam int unsigned W_COORD      = 3;
    localparam int unsigned W_IDX        = 6;
    localparam int unsigned W_VIDA       = 2;
    localparam int unsigned W_ALVOS      = 6;
    localparam int unsigned W_ESTADO     = 3;
    localparam int unsigned W_TIMER      = 26;

    typedef enum logic [W_ESTADO-1:0] {
        OCIOSO  = 3'd0,
        JOGANDO = 3'd1,
        AVALIA  = 3'd2,
        VITORIA = 3'd3,
        DERROTA = 3'd4
    } estado_t;

    typedef struct packed {
        logic [W_COORD-1:0] coluna;
        logic [W_COORD-1:0] linha;
    } coord_t;

    // Column-major cell index: coluna*7 + linha.
    function automatic logic [W_IDX-1:0] indice_celula(input logic [W_COORD-1:0] coluna,
                                                        input logic [W_COORD-1:0] linha);
        return W_IDX'(W_IDX'(coluna) * W_IDX'(NUM_LINHAS) + W_IDX'(linha));
    endfunction

    function automatic logic [W_ALVOS-1:0] conta_alvos(input logic [NUM_CELULAS-1:0] m);
        logic [W_ALVOS-1:0] soma;
        soma = '0;
        for (int i = 0; i < int'(NUM_CELULAS); i++) begin
            soma = soma + W_ALVOS'(m[i]);
        end
        return soma;
    endfunction

endpackage

// File: rtl/sincronizador_borda.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// registered rising-edge detector producing a single-cycle pulse.
module sincronizador_borda (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dado_i,
    output logic pulso_o
);

    logic meta_q;
    logic sinc_q;
    logic ant_q;
    logic pulso_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            sinc_q  <= 1'b0;
            ant_q   <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            meta_q  <= dado_i;
            sinc_q  <= meta_q;
            ant_q   <= sinc_q;
            pulso_q <= sinc_q & ~ant_q;
        end
    end

    assign pulso_o = pulso_q;

endmodule

// File: rtl/controlador_de_partida.sv
// Single-clock round controller for the 5x7 naval-battle board.
// Define TIMEOUT_EN to add a per-attack timer that forces a miss on expiry.
module controlador_de_partida
    import partida_pkg::*;
#(
    parameter int unsigned VIDAS_INICIAIS = 3,
    parameter int unsigned TEMPO_LIMITE   = 50_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   confirmar,
    input  logic [W_COORD-1:0]     coordColuna,
    input  logic [W_COORD-1:0]     coordLinha,
    input  logic [NUM_CELULAS-1:0] mapa,
    output logic [NUM_CELULAS-1:0] matriz,
    output logic [W_VIDA-1:0]      vida,
    output logic [W_ALVOS-1:0]     alvos_restantes,
    output logic [W_ESTADO-1:0]    estado,
    output logic                   erro_coord,
    output logic                   LED_R,
    output logic                   LED_G,
    output logic                   LED_B
);

    logic inicio_p;
    logic confirma_p;

    sincronizador_borda u_sinc_iniciar (
        .clk_i   (clock),
        .rst_i   (reset),
        .dado_i  (iniciar),
        .pulso_o (inicio_p)
    );

    sincronizador_borda u_sinc_confirmar (
        .clk_i   (clock),
        .rst_i   (reset),
        .dado_i  (confirmar),
        .pulso_o (confirma_p)
    );

    estado_t               estado_q;
    logic [NUM_CELULAS-1:0] mapa_q;
    logic [NUM_CELULAS-1:0] matriz_q;
    logic [W_VIDA-1:0]      vida_q;
    logic [W_ALVOS-1:0]     alvos_q;
    coord_t                 coord_q;
    logic                   erro_q;
    logic                   led_r_q;
    logic                   led_g_q;
    logic                   led_b_q;

    logic                   coord_valida;
    logic [NUM_CELULAS-1:0] mascara;
    logic                   ja_atacada;
    logic                   acerto;
    logic [W_ALVOS-1:0]     alvos_mapa;

    assign coord_valida = (coordColuna < W_COORD'(NUM_COLUNAS)) &&
                          (coordLinha  < W_COORD'(NUM_LINHAS));
    assign mascara      = NUM_CELULAS'(1) << indice_celula(coord_q.coluna, coord_q.linha);
    assign ja_atacada   = |(matriz_q & mascara);
    assign acerto       = |(mapa_q & mascara);
    assign alvos_mapa   = conta_alvos(mapa);

`ifdef TIMEOUT_EN
    logic [W_TIMER-1:0] timer_q;
    logic               expira;
    assign expira = (timer_q == W_TIMER'(TEMPO_LIMITE - 1));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            mapa_q   <= '0;
            matriz_q <= '0;
            vida_q   <= '0;
            alvos_q  <= '0;
            coord_q  <= '0;
            erro_q   <= 1'b0;
            led_r_q  <= 1'b0;
            led_g_q  <= 1'b0;
            led_b_q  <= 1'b0;
`ifdef TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            erro_q <= 1'b0;
            case (estado_q)
                // Idle and end-of-round states all restart on iniciar.
                OCIOSO, VITORIA, DERROTA: begin
                    if (inicio_p) begin
                        mapa_q   <= mapa;
                        alvos_q  <= alvos_mapa;
                        vida_q   <= W_VIDA'(VIDAS_INICIAIS);
                        matriz_q <= '0;
                        led_r_q  <= 1'b0;
                        led_b_q  <= 1'b0;
`ifdef TIMEOUT_EN
                        timer_q  <= '0;
`endif
                        if (alvos_mapa == '0) begin
                            estado_q <= VITORIA;
                            led_g_q  <= 1'b1;
                        end else begin
                            estado_q <= JOGANDO;
                            led_g_q  <= 1'b0;
                        end
                    end
                end

                JOGANDO: begin
                    if (confirma_p) begin
                        if (!coord_valida) begin
                            erro_q <= 1'b1;
                        end else begin
                            coord_q  <= '{coluna: coordColuna, linha: coordLinha};
                            estado_q <= AVALIA;
                        end
                    end
`ifdef TIMEOUT_EN
                    // A confirm in the expiry cycle wins; the timeout is dropped.
                    if (!confirma_p && expira) begin
                        timer_q <= '0;
                        led_r_q <= 1'b1;
                        led_g_q <= 1'b0;
                        led_b_q <= 1'b0;
                        if (vida_q > '0) begin
                            vida_q <= vida_q - W_VIDA'(1);
                            if (vida_q == W_VIDA'(1)) begin
                                estado_q <= DERROTA;
                            end
                        end
                    end else begin
                        timer_q <= timer_q + W_TIMER'(1);
                    end
`endif
                end

                AVALIA: begin
`ifdef TIMEOUT_EN
                    timer_q <= '0;
`endif
                    if (ja_atacada) begin
                        led_r_q  <= 1'b0;
                        led_g_q  <= 1'b0;
                        led_b_q  <= 1'b1;
                        estado_q <= JOGANDO;
                    end else if (acerto) begin
                        matriz_q <= matriz_q | mascara;
                        led_r_q  <= 1'b0;
                        led_g_q  <= 1'b1;
                        led_b_q  <= 1'b0;
                        if (alvos_q > '0) begin
                            alvos_q <= alvos_q - W_ALVOS'(1);
                        end
                        estado_q <= (alvos_q <= W_ALVOS'(1)) ? VITORIA : JOGANDO;
                    end else begin
                        matriz_q <= matriz_q | mascara;
                        led_r_q  <= 1'b1;
                        led_g_q  <= 1'b0;
                        led_b_q  <= 1'b0;
                        if (vida_q > '0) begin
                            vida_q <= vida_q - W_VIDA'(1);
                        end
                        estado_q <= (vida_q <= W_VIDA'(1)) ? DERROTA : JOGANDO;
                    end
                end

                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign matriz          = matriz_q;
    assign vida            = vida_q;
    assign alvos_restantes = alvos_q;
    assign estado          = estado_q;
    assign erro_coord      = erro_q;
    assign LED_R           = led_r_q;
    assign LED_G           = led_g_q;
    assign LED_B           = led_b_q;

endmodule

// File: tb/tb_controlador_de_partida.sv
// Directed self-checking bench for controlador_de_partida; with TIMEOUT_EN
// defined it exercises the attack timer with a 20-cycle limit instead.
module tb_controlador_de_partida;

    localparam int unsigned TB_LIMITE = 20;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic        confirmar;
    logic [2:0]  coordColuna;
    logic [2:0]  coordLinha;
    logic [34:0] mapa;
    logic [34:0] matriz;
    logic [1:0]  vida;
    logic [5:0]  alvos_restantes;
    logic [2:0]  estado;
    logic        erro_coord;
    logic        LED_R;
    logic        LED_G;
    logic        LED_B;

    int total;
    int passed;
    int err_cnt;

    controlador_de_partida #(
        .VIDAS_INICIAIS (3),
        .TEMPO_LIMITE   (TB_LIMITE)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .confirmar       (confirmar),
        .coordColuna     (coordColuna),
        .coordLinha      (coordLinha),
        .mapa            (mapa),
        .matriz          (matriz),
        .vida            (vida),
        .alvos_restantes (alvos_restantes),
        .estado          (estado),
        .erro_coord      (erro_coord),
        .LED_R           (LED_R),
        .LED_G           (LED_G),
        .LED_B           (LED_B)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (erro_coord === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic start_round();
        iniciar = 1'b1;
        repeat (2) @(negedge clock);
        iniciar = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic attack(input logic [2:0] col, input logic [2:0] lin);
        coordColuna = col;
        coordLinha  = lin;
        confirmar   = 1'b1;
        repeat (2) @(negedge clock);
        confirmar = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        bit reached;
        total = 0; passed = 0; err_cnt = 0;
        reset = 1'b1; iniciar = 1'b0; confirmar = 1'b0;
        coordColuna = '0; coordLinha = '0; mapa = 35'h71;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_estado", 64'(estado), 64'd0);
        check("reset_matriz", 64'(matriz), 64'd0);
        check("reset_vida_alvos", 64'({vida, alvos_restantes}), 64'd0);
        check("reset_leds_erro", 64'({LED_R, LED_G, LED_B, erro_coord}), 64'd0);

`ifdef TIMEOUT_EN
        start_round();
        check("to_start_estado", 64'(estado), 64'd1);
        check("to_start_vida", 64'(vida), 64'd3);
        repeat (16) @(negedge clock);
        check("to_vida", 64'(vida), 64'd2);
        check("to_leds", 64'({LED_R, LED_G, LED_B}), 64'b100);
        check("to_matriz", 64'(matriz), 64'd0);
        check("to_estado", 64'(estado), 64'd1);
`else
        start_round();
        check("start_estado", 64'(estado), 64'd1);
        check("start_vida", 64'(vida), 64'd3);
        check("start_alvos", 64'(alvos_restantes), 64'd4);
        mapa = 35'h0;

        attack(3'd0, 3'd0);
        check("hit00_leds", 64'({LED_R, LED_G, LED_B}), 64'b010);
        check("hit00_alvos", 64'(alvos_restantes), 64'd3);
        check("hit00_matriz", 64'(matriz), 64'h1);
        check("hit00_vida", 64'(vida), 64'd3);

        attack(3'd1, 3'd5);
        check("miss15_leds", 64'({LED_R, LED_G, LED_B}), 64'b100);
        check("miss15_vida", 64'(vida), 64'd2);
        check("miss15_matriz", 64'(matriz), 64'h1001);

        attack(3'd0, 3'd0);
        check("rep00_leds", 64'({LED_R, LED_G, LED_B}), 64'b001);
        check("rep00_vida_alvos", 64'({vida, alvos_restantes}), 64'({2'd2, 6'd3}));
        check("rep00_matriz", 64'(matriz), 64'h1001);

        err_cnt = 0;
        attack(3'd5, 3'd0);
        check("err50_count", 64'(err_cnt), 64'd1);
        attack(3'd2, 3'd7);
        check("err27_count", 64'(err_cnt), 64'd2);
        check("err_estado", 64'(estado), 64'd1);
        check("err_vida_alvos", 64'({vida, alvos_restantes}), 64'({2'd2, 6'd3}));
        check("err_matriz", 64'(matriz), 64'h1001);

        attack(3'd0, 3'd4);
        attack(3'd0, 3'd5);
        check("hit05_alvos", 64'(alvos_restantes), 64'd1);
        check("hit05_estado", 64'(estado), 64'd1);
        attack(3'd0, 3'd6);
        check("win_alvos", 64'(alvos_restantes), 64'd0);
        check("win_estado", 64'(estado), 64'd3);
        check("win_leds", 64'({LED_R, LED_G, LED_B}), 64'b010);
        check("win_matriz", 64'(matriz), 64'h1071);

        attack(3'd1, 3'd0);
        check("win_ignore_estado", 64'(estado), 64'd3);
        check("win_ignore_matriz", 64'(matriz), 64'h1071);

        mapa = 35'h71;
        start_round();
        check("restart_estado", 64'(estado), 64'd1);
        check("restart_matriz", 64'(matriz), 64'd0);
        check("restart_vida_alvos", 64'({vida, alvos_restantes}), 64'({2'd3, 6'd4}));
        check("restart_leds", 64'({LED_R, LED_G, LED_B}), 64'b000);

        attack(3'd1, 3'd0);
        attack(3'd1, 3'd1);
        check("miss2_vida", 64'(vida), 64'd1);
        attack(3'd1, 3'd2);
        check("lose_vida", 64'(vida), 64'd0);
        check("lose_estado", 64'(estado), 64'd4);
        check("lose_leds", 64'({LED_R, LED_G, LED_B}), 64'b100);
        check("lose_matriz", 64'(matriz), 64'h380);

        start_round();
        check("restart2_estado", 64'(estado), 64'd1);
        coordColuna = 3'd2; coordLinha = 3'd0;
        confirmar = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (estado == 3'd2) begin
                reached = 1'b1;
                break;
            end
        end
        check("avalia_reached", 64'(reached), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_estado", 64'(estado), 64'd0);
        check("abort_matriz_vida", 64'({matriz, vida}), 64'd0);
        check("abort_leds", 64'({LED_R, LED_G, LED_B}), 64'b000);
        confirmar = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        mapa = 35'h0;
        start_round();
        check("empty_estado", 64'(estado), 64'd3);
        check("empty_alvos", 64'(alvos_restantes), 64'd0);
        check("empty_leds", 64'({LED_R, LED_G, LED_B}), 64'b010);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/controlador_de_partida.md
Name: controlador_de_partida

Overview:
- Sequencing controller for one naval-battle round on the 5-column x 7-row LED board.
- Latches the secret map at round start and takes synchronized attack confirmations.
- Resolves each attack as hit, miss or repeat; maintains the revealed matrix, remaining targets and lives, and drives the status LEDs.
- Sits between the board's buttons/switches and the matrix display driver, replacing free-running button-clocked logic with a single-clock FSM.

Parameters:
- VIDAS_INICIAIS, 3: lives loaded at round start (1..3).
- TEMPO_LIMITE, 50_000_000: cycles allowed per attack before a timeout miss (used only with TIMEOUT_EN).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  raw start button, level, asynchronous to clock
- confirmar  in  1  raw attack-confirm button, level, asynchronous to clock
- coordColuna  in  3  target column (valid 0..4)
- coordLinha  in  3  target row (valid 0..6)
- mapa  in  35  secret map; bit index = coluna*7 + linha; 1 = ship cell
- matriz  out  35  revealed cells, same indexing; 1 = already attacked
- vida  out  2  remaining lives
- alvos_restantes  out  6  ship cells not yet hit
- estado  out  3  current FSM state code
- erro_coord  out  1  one-cycle pulse: confirm with an out-of-range coordinate
- LED_R, LED_G, LED_B  out  1 each  status LEDs

Behaviour:
- Reset (async, active-high): state OCIOSO; matriz=0; vida=0; alvos_restantes=0; erro_coord=0; all LEDs 0; synchronizer flops cleared.
- Inputs iniciar and confirmar each pass through a 2-FF synchronizer plus a rising-edge detector, giving a 1-cycle pulse. Pulse appears 3 edges after the first edge that samples the raw input high.
- States: OCIOSO=0, JOGANDO=1, AVALIA=2, VITORIA=3, DERROTA=4.
- OCIOSO: on iniciar pulse, load the following and go to JOGANDO:
  - mapa_reg<=mapa
  - alvos_restantes<=popcount(mapa)
  - vida<=VIDAS_INICIAIS
  - matriz<=0
  - LEDs<=0
- OCIOSO with popcount(mapa)=0: go directly to VITORIA.
- JOGANDO, confirm pulse with coordColuna>4 or coordLinha>6: pulse erro_coord; stay in JOGANDO; no other change.
- JOGANDO, valid confirm pulse: latch the coordinate and go to AVALIA.
- AVALIA lasts exactly 1 cycle, then resolves one of three cases:
  - Repeat (matriz bit already 1): no counter change; LED_B=1, LED_R=0, LED_G=0; return to JOGANDO.
  - Hit (mapa_reg bit 1): set the matriz bit; alvos_restantes-1; LED_G=1, others 0. If the new count is 0, go to VITORIA, else return to JOGANDO.
  - Miss: set the matriz bit; vida-1; LED_R=1, others 0. If the new vida is 0, go to DERROTA, else return to JOGANDO.
- Latency: confirm pulse edge -> AVALIA -> results visible after the next edge (2 edges after the pulse).
- mapa changes after round start are ignored (mapa_reg is used).
- iniciar pulse in JOGANDO or AVALIA is ignored.
- VITORIA: LED_G=1 steady. DERROTA: LED_R=1 steady. Both hold matriz and counters.
- From VITORIA or DERROTA, an iniciar pulse restarts the round exactly as from OCIOSO. Confirm pulses are ignored in these states.
- Confirm and iniciar pulses in the same cycle: the state's rule applies (OCIOSO/VITORIA/DERROTA take iniciar; JOGANDO takes confirmar).
- Counters never underflow: decrements are only issued when the value is greater than 0.
- Reset asserted in any state, including AVALIA, aborts immediately to reset values.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined: a 26-bit attack timer is cleared on entering JOGANDO and counts while in JOGANDO. At TEMPO_LIMITE-1 it forces a miss: vida-1, LED_R=1, no matriz change, DERROTA if vida reaches 0. The timer then restarts.
- A confirm pulse in the same cycle as expiry takes priority; the timeout is discarded.
- Undefined: no timer logic; JOGANDO waits indefinitely.

Decomposition:
- Package partida_pkg holds:
  - state encoding constants
  - NUM_COLUNAS=5, NUM_LINHAS=7, NUM_CELULAS=35
  - the cell-index function (coluna*7+linha)
- Sub-module sincronizador_borda: 2-FF synchronizer plus rising-edge pulse, async active-high reset. Instantiated twice, for iniciar and confirmar.

Test Plan:
- Map with cells 0, 4, 5, 6 set (column 0 = 7'b1110001), VIDAS_INICIAIS=3. Start, then confirm (0,0) -> LED_G=1, alvos_restantes 4->3, matriz[0]=1, vida=3.
- Same round, confirm (1,5) -> miss: LED_R=1, vida=2, matriz[12]=1.
- Confirm (0,0) again -> LED_B=1, vida=2, alvos_restantes=3, matriz unchanged.
- Confirm (5,0), then (2,7) -> one erro_coord pulse each, state stays JOGANDO (1), no counter changes.
- Hit cells 4, 5, 6 -> alvos_restantes=0, estado=VITORIA (3), LED_G steady. A further confirm is ignored; iniciar restarts with matriz=0 and vida=3.
- Three misses -> vida=0, estado=DERROTA (4), LED_R steady. Assert reset mid-AVALIA in a new round -> estado=0, matriz=0, vida=0, LEDs=0.
- TIMEOUT_EN with TEMPO_LIMITE=20: idle in JOGANDO for 20 cycles -> vida drops by 1 and LED_R=1.
